hsid_band_packer: RTL and testbench



---
 rtl/hsid_band_packer.sv | 126 ++++++++++++
 tb/tb_hsid_band_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hsid_band_packer.sv
// Producer side of the HSID captured-pixel FIFO: packs pairs of band samples
// into double-width FIFO words and tags the final pack of each pixel.
module hsid_band_packer #(
    parameter int unsigned WORD_WIDTH      = 16,
    parameter int unsigned HSP_BANDS_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       start,
    input  logic [HSP_BANDS_WIDTH-1:0] hsp_bands,
    input  logic [WORD_WIDTH-1:0]      band_data,
    input  logic                       band_valid,
    output logic                       band_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [2*WORD_WIDTH-1:0]    fifo_wr_data,
    output logic                       pack_last,
    output logic                       idle,
    output logic                       ready,
    output logic                       done,
    output logic                       error,
    output logic                       cancelled
);

    localparam logic [2:0] PK_IDLE   = 3'd0;
    localparam logic [2:0] PK_CONFIG = 3'd1;
    localparam logic [2:0] PK_LOW    = 3'd2;
    localparam logic [2:0] PK_HIGH   = 3'd3;
    localparam logic [2:0] PK_WRITE  = 3'd4;
    localparam logic [2:0] PK_DONE   = 3'd5;
    localparam logic [2:0] PK_ERROR  = 3'd6;
    localparam logic [2:0] PK_CLEAR  = 3'd7;

    localparam logic [HSP_BANDS_WIDTH-1:0] ONE = HSP_BANDS_WIDTH'(1);
    localparam logic [HSP_BANDS_WIDTH-1:0] TWO = HSP_BANDS_WIDTH'(2);

    logic [2:0]                 state;
    logic [HSP_BANDS_WIDTH-1:0] cfg_hsp_bands;
    logic [HSP_BANDS_WIDTH-1:0] cfg_pack_threshold;
    logic [HSP_BANDS_WIDTH-1:0] band_count;
    logic [HSP_BANDS_WIDTH-1:0] pack_count;
    logic [2*WORD_WIDTH-1:0]    pack;
    logic                       last_pack;
    logic                       odd_tail;

    always_comb begin
        band_ready   = (state == PK_LOW) || (state == PK_HIGH);
        ready        = band_ready;
        idle         = (state == PK_IDLE);
        done         = (state == PK_DONE);
        error        = (state == PK_ERROR);
        cancelled    = (state == PK_CLEAR);
        fifo_wr_en   = (state == PK_WRITE) && !fifo_full && !clear;
        last_pack    = (pack_count == cfg_pack_threshold - ONE);
        pack_last    = fifo_wr_en && last_pack;
        odd_tail     = (band_count == cfg_hsp_bands - ONE);
        fifo_wr_data = pack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= PK_IDLE;
            cfg_hsp_bands      <= '1;
            cfg_pack_threshold <= '1;
            band_count         <= '0;
            pack_count         <= '0;
            pack               <= '0;
        end else begin
            case (state)
                PK_IDLE: begin
                    if (start) state <= PK_CONFIG;
                end
                PK_CONFIG: begin
                    // ceil(bands/2) written as half plus the odd bit so all-ones cannot wrap
                    cfg_hsp_bands      <= hsp_bands;
                    cfg_pack_threshold <= (hsp_bands >> 1) + {{(HSP_BANDS_WIDTH-1){1'b0}}, hsp_bands[0]};
                    if (clear)                 state <= PK_CLEAR;
                    else if (hsp_bands < TWO)  state <= PK_ERROR;
                    else                       state <= PK_LOW;
                end
                PK_LOW: begin
                    if (clear) begin
                        state <= PK_CLEAR;
                    end else if (band_valid) begin
                        pack[WORD_WIDTH-1:0] <= band_data;
                        band_count           <= band_count + ONE;
                        if (odd_tail) begin
                            pack[2*WORD_WIDTH-1:WORD_WIDTH] <= '0;
                            state                           <= PK_WRITE;
                        end else begin
                            state <= PK_HIGH;
                        end
                    end
                end
                PK_HIGH: begin
                    if (clear) begin
                        state <= PK_CLEAR;
                    end else if (band_valid) begin
                        pack[2*WORD_WIDTH-1:WORD_WIDTH] <= band_data;
                        band_count                      <= band_count + ONE;
                        state                           <= PK_WRITE;
                    end
                end
                PK_WRITE: begin
                    if (clear) begin
                        state <= PK_CLEAR;
                    end else if (!fifo_full) begin
                        pack_count <= pack_count + ONE;
                        state      <= last_pack ? PK_DONE : PK_LOW;
                    end
                end
                PK_DONE, PK_ERROR, PK_CLEAR: begin
                    state              <= PK_IDLE;
                    band_count         <= '0;
                    pack_count         <= '0;
                    pack               <= '0;
                    cfg_hsp_bands      <= '1;
                    cfg_pack_threshold <= '1;
                end
                default: state <= PK_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsid_band_packer.sv
// Directed, table-driven bench for hsid_band_packer with hand-written
// sequences for FIFO back-pressure, clear and asynchronous reset.
`timescale 1ns/1ps
module tb_hsid_band_packer;

    localparam int unsigned WW = 16;
    localparam int unsigned BW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              start;
    logic [BW-1:0]     hsp_bands;
    logic [WW-1:0]     band_data;
    logic              band_valid;
    logic              band_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [2*WW-1:0]   fifo_wr_data;
    logic              pack_last;
    logic              idle, ready, done, error, cancelled;

    always #5 clk = ~clk;

    hsid_band_packer #(.WORD_WIDTH(WW), .HSP_BANDS_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .hsp_bands(hsp_bands), .band_data(band_data), .band_valid(band_valid),
        .band_ready(band_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .pack_last(pack_last), .idle(idle),
        .ready(ready), .done(done), .error(error), .cancelled(cancelled)
    );

    typedef struct {
        int bands;
        int tog;
        int exp_writes;
        int exp_accepts;
        int exp_error;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0] mem [0:255];

    // Monitor-owned statistics; the main flow only snapshots and reads them.
    int            acc_cnt = 0, cyc = 0, done_n = 0, err_n = 0, canc_n = 0;
    int            ready_n = 0, last_wr_cyc = 0, done_cyc = 0, bad_last = 0;
    logic [2*WW:0] wrq[$];

    int acc_base, wr_base, done_base, err_base, canc_base, ready_base;
    bit toggle_mode = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (band_valid && band_ready) acc_cnt++;
            if (band_ready) ready_n++;
            if (fifo_wr_en) begin
                wrq.push_back({pack_last, fifo_wr_data});
                if (pack_last) last_wr_cyc = cyc;
            end
            if (pack_last && !fifo_wr_en) bad_last = 1;
            if (done) begin done_n++; done_cyc = cyc; end
            if (error) err_n++;
            if (cancelled) canc_n++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        int idx;
        @(posedge clk);
        #1;
        idx = acc_cnt - acc_base;
        band_data  = (idx >= 0 && idx < 256) ? mem[idx] : '0;
        band_valid = toggle_mode ? ~band_valid : 1'b1;
    endtask

    task automatic begin_pixel(input int bands, input bit tog);
        toggle_mode = tog;
        acc_base    = acc_cnt;
        wr_base     = wrq.size();
        done_base   = done_n;
        err_base    = err_n;
        canc_base   = canc_n;
        ready_base  = ready_n;
        hsp_bands   = BW'(bands);
        band_valid  = 1'b1;
        band_data   = mem[0];
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_n == done_base && err_n == err_base && canc_n == canc_base && n < budget) begin
            step();
            n++;
        end
        check("end_timeout", (n >= budget), 0);
    endtask

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*WW:0] e;
        logic [WW-1:0] lo, hi;
        int nw;

        for (int k = 0; k < 256; k++) mem[k] = WW'(k + 1);
        vecs[0] = '{4,   0, 2,   4,   0};
        vecs[1] = '{5,   0, 3,   5,   0};
        vecs[2] = '{6,   1, 3,   6,   0};
        vecs[3] = '{2,   0, 1,   2,   0};
        vecs[4] = '{3,   1, 2,   3,   0};
        vecs[5] = '{1,   0, 0,   0,   1};
        vecs[6] = '{0,   0, 0,   0,   1};
        vecs[7] = '{255, 0, 128, 255, 0};

        rst_n = 1'b0; clear = 1'b0; start = 1'b0; hsp_bands = '0;
        band_data = '0; band_valid = 1'b0; fifo_full = 1'b0;
        #3;
        check("rst_idle", idle, 1);
        check("rst_band_ready", band_ready, 0);
        check("rst_ready", ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_pack_last", pack_last, 0);
        check("rst_status", {done, error, cancelled}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven pixels
        for (int v = 0; v < 8; v++) begin
            begin_pixel(vecs[v].bands, vecs[v].tog != 0);
            wait_end(2000);
            nw = wrq.size() - wr_base;
            check("writes", nw, vecs[v].exp_writes);
            check("accepts", acc_cnt - acc_base, vecs[v].exp_accepts);
            check("error_pulses", err_n - err_base, vecs[v].exp_error);
            check("done_pulses", done_n - done_base, (vecs[v].exp_error != 0) ? 0 : 1);
            check("idle_after", idle, 1);
            check("status_one_cycle", {done, error}, 0);
            if (vecs[v].exp_error != 0)
                check("ready_never", ready_n - ready_base, 0);
            else
                check("done_latency", done_cyc - last_wr_cyc, 1);
            for (int i = 0; i < nw; i++) begin
                e  = wrq[wr_base + i];
                lo = mem[2*i];
                hi = (2*i + 1 < vecs[v].bands) ? mem[2*i + 1] : '0;
                check("wr_data", e[2*WW-1:0], {hi, lo});
                check("wr_last", e[2*WW], (i == nw - 1) ? 1 : 0);
            end
        end

        // FIFO back-pressure on the first pack
        fifo_full = 1'b1;
        begin_pixel(4, 0);
        for (int n = 0; n < 20 && !((acc_cnt - acc_base) == 2 && !band_ready); n++) step();
        for (int k = 0; k < 3; k++) begin
            check("stall_wr_en", fifo_wr_en, 0);
            check("stall_band_ready", band_ready, 0);
            check("stall_wr_data", fifo_wr_data, 32'h0002_0001);
            step();
        end
        fifo_full = 1'b0;
        #1;
        check("stall_release_wr_en", fifo_wr_en, 1);
        check("stall_release_data", fifo_wr_data, 32'h0002_0001);
        check("stall_release_last", pack_last, 0);
        wait_end(200);
        check("stall_writes", wrq.size() - wr_base, 2);
        if (wrq.size() - wr_base == 2) begin
            check("stall_wr0", wrq[wr_base], 33'h0_0002_0001);
            check("stall_wr1", wrq[wr_base + 1], 33'h1_0004_0003);
        end

        // Clear while waiting for the high sample
        begin_pixel(4, 0);
        for (int n = 0; n < 20 && !((acc_cnt - acc_base) == 1 && band_ready); n++) step();
        check("clr_in_high", band_ready, 1);
        clear = 1'b1;
        band_valid = 1'b0;
        step();
        clear = 1'b0;
        band_valid = 1'b0;
        check("clr_cancelled", cancelled, 1);
        check("clr_no_wr", fifo_wr_en, 0);
        step();
        check("clr_idle", idle, 1);
        check("clr_cancel_once", cancelled, 0);
        check("clr_writes", wrq.size() - wr_base, 0);
        check("clr_accepts", acc_cnt - acc_base, 1);

        mem[0] = 16'hAAAA;
        mem[1] = 16'hBBBB;
        begin_pixel(2, 0);
        wait_end(200);
        check("after_clr_writes", wrq.size() - wr_base, 1);
        if (wrq.size() - wr_base == 1)
            check("after_clr_data", wrq[wr_base], 33'h1_BBBB_AAAA);
        mem[0] = 16'h0001;
        mem[1] = 16'h0002;

        // Asynchronous reset while stalled in WRITE
        fifo_full = 1'b1;
        begin_pixel(4, 0);
        repeat (3) step();
        check("mid_rst_in_write", {band_ready, idle}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_idle", idle, 1);
        check("mid_rst_wr_en", fifo_wr_en, 0);
        check("mid_rst_data", fifo_wr_data, 0);
        check("mid_rst_ready", band_ready, 0);
        fifo_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("mid_rst_stays_idle", idle, 1);
        check("mid_rst_no_write", wrq.size() - wr_base, 0);

        check("pack_last_qualified", bad_last, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
